// File: rtl/cache_ctrl_pkg.sv
// Shared types and helpers for the data-cache miss sequencer.
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  localparam int DEFAULT_WORDS_PER_LINE = 4;

  // Smallest r with 2**r >= v; elaboration-time only.
  function automatic int log2_ceil(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_perf_counter.sv
// Saturating event counter used for cache miss statistics.
module cache_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss sequencer for a direct-mapped write-back data cache: stall, writeback, refill, tag update.
// Optional miss counter enabled by defining CACHE_MISS_CTRL_PERF_EN.
module cache_miss_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int  WORDS_PER_LINE = DEFAULT_WORDS_PER_LINE,
  parameter int  CNT_W          = 32,
  localparam int BEAT_W         = log2_ceil(WORDS_PER_LINE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic              hit,
  input  logic              line_dirty,
  input  logic              mem_ack,
  output logic              stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [BEAT_W-1:0] beat,
  output logic              data_we,
  output logic              cpu_we,
  output logic              tag_we,
  output logic              set_dirty,
  output logic              dirty_next,
  output logic [CNT_W-1:0]  miss_count
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

  state_t            state_reg, state_next;
  logic [BEAT_W-1:0] beat_reg, beat_next;
  logic              pend_wr_reg, pend_wr_next;
  logic              req;

  assign req = cpu_read | cpu_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      beat_reg    <= '0;
      pend_wr_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      beat_reg    <= beat_next;
      pend_wr_reg <= pend_wr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    beat_next    = beat_reg;
    pend_wr_next = pend_wr_reg;
    stall        = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    data_we      = 1'b0;
    cpu_we       = 1'b0;
    tag_we       = 1'b0;
    set_dirty    = 1'b0;
    dirty_next   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (req) begin
          if (hit) begin
            // A simultaneous read+write is treated as a store.
            cpu_we    = cpu_write;
            set_dirty = cpu_write;
          end else begin
            stall        = 1'b1;
            pend_wr_next = cpu_write;
            beat_next    = '0;
            state_next   = line_dirty ? WRITEBACK : REFILL;
          end
        end
      end
      WRITEBACK: begin
        stall     = 1'b1;
        mem_write = 1'b1;
        if (mem_ack) begin
          beat_next = beat_reg + 1'b1;
          if (beat_reg == LAST_BEAT) state_next = REFILL;
        end
      end
      REFILL: begin
        stall    = 1'b1;
        mem_read = 1'b1;
        data_we  = mem_ack;
        if (mem_ack) begin
          beat_next = beat_reg + 1'b1;
          if (beat_reg == LAST_BEAT) state_next = UPDATE;
        end
      end
      UPDATE: begin
        stall      = 1'b1;
        tag_we     = 1'b1;
        dirty_next = pend_wr_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Outputs are quiet for as long as reset is held, even mid-cycle.
    if (reset) begin
      stall      = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      data_we    = 1'b0;
      cpu_we     = 1'b0;
      tag_we     = 1'b0;
      set_dirty  = 1'b0;
      dirty_next = 1'b0;
    end
  end

  assign beat = beat_reg;

`ifdef CACHE_MISS_CTRL_PERF_EN
  logic miss_pulse;

  assign miss_pulse = (state_reg == IDLE) && req && !hit && !reset;

  cache_perf_counter #(
    .CNT_W(CNT_W)
  ) u_perf_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (miss_pulse),
    .count(miss_count)
  );
`else
  assign miss_count = '0;
`endif

endmodule
